// File: rtl/qformat_dot.sv
// Signed Q-format dot-product engine: full-precision multiply-accumulate of LEN
// operand pairs, then round-half-up and saturate back to the operand format.
module qformat_dot #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FRAC  = 4,
    parameter int unsigned LEN   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned ACC_W  = PROD_W + $clog2(LEN) + 1;
    localparam int unsigned RND_W  = ACC_W + 1;
    localparam int unsigned CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned EXT_W  = ACC_W - PROD_W;
    localparam int unsigned PAD_W  = RND_W - (WIDTH - 1);

    localparam logic [CNT_W-1:0]        LAST = CNT_W'(LEN - 1);
    localparam logic signed [RND_W-1:0] HALF = RND_W'(1) << (FRAC - 1);
    localparam logic signed [RND_W-1:0] MAXV = {{PAD_W{1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RND_W-1:0] MINV = {{PAD_W{1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ROUND = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  cnt;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [RND_W-1:0]  acc_wide;
    logic signed [RND_W-1:0]  rnd;
    logic        [WIDTH-1:0]  sat_data;
    logic                     sat_flag;

    // Full-precision product and accumulate path.
    always_comb begin
        prod     = $signed(in_a) * $signed(in_b);
        prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};
        acc_next = acc + prod_ext;
    end

    // Round half toward +inf (arithmetic shift floors), then clip to WIDTH.
    always_comb begin
        acc_wide = {acc[ACC_W-1], acc};
        rnd      = (acc_wide + HALF) >>> FRAC;
        sat_data = rnd[WIDTH-1:0];
        sat_flag = 1'b0;
        if (rnd > MAXV) begin
            sat_data = {1'b0, {(WIDTH-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (rnd < MINV) begin
            sat_data = {1'b1, {(WIDTH-1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= acc_next;
                        if (cnt == LAST) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= ROUND;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ROUND: begin
                    out_data  <= sat_data;
                    out_sat   <= sat_flag;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    state     <= OUT;
                end
                OUT: begin
                    // Result held until the downstream handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
